// File: rtl/rs232_tx_arb.sv
// -----------------------------------------------------------------------------
// rs232_tx_arb
//   Shares one valid/ready byte transmitter (rs232_send3) between NUM_REQ
//   byte-stream requesters. Arbitration is round-robin and packet-locked: the
//   owner keeps the transmitter until it transfers a byte flagged req_last, or
//   until MAX_BURST bytes have gone out (MAX_BURST = 0 means unlimited). When
//   HEADER_EN = 1 a channel-ID byte {4'hA, 1'b0, k[2:0]} precedes each burst so
//   the host can demultiplex the streams.
//
// Ports
//   clock      system clock, rising edge
//   resetn     asynchronous active-low reset
//   req_data   byte of requester i on bits [8i+7:8i]
//   req_valid  requester i has a byte
//   req_last   requester i's current byte ends its packet
//   req_ready  byte of requester i is accepted this cycle
//   out_data   byte to the transmitter
//   out_valid  out_data is valid
//   out_ready  transmitter accepts out_data
//   grant      one-hot owner, all zero when idle
//   busy       1 while a burst (header or data) is in progress
// -----------------------------------------------------------------------------
module rs232_tx_arb #(
  parameter int NUM_REQ   = 4,
  parameter bit HEADER_EN = 1'b1,
  parameter int MAX_BURST = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_e;

  localparam logic [2:0] LAST_RST  = 3'(NUM_REQ - 1);
  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

  state_e               state_q, state_d;
  logic [2:0]           owner_q;     // index k of the current owner
  logic [2:0]           last_q;      // round-robin pointer: last released owner
  logic [7:0]           cnt_q;       // data bytes sent in this burst
  logic [7:0]           hdr_q;       // channel-ID byte for this burst
  logic [NUM_REQ-1:0]   grant_q;

  logic                 win_found;
  logic [2:0]           win_idx;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [3:0]           cand;

  logic [7:0]           own_data;
  logic                 own_valid;
  logic                 own_last;
  logic                 xfer;
  logic                 burst_full;
  logic                 release_burst;

  // ---------------------------------------------------------------------------
  // Round-robin search: start one past the last owner and wrap, so the most
  // recently released requester has the lowest priority.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the loops or branches leaves it unassigned (which would infer a
    // latch).
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    cand       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, last_q} + 4'(off);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!win_found && cand == 4'(j) && req_valid[j]) begin
          win_found = 1'b1;
          win_idx   = 3'(j);
        end
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      win_onehot[j] = (win_idx == 3'(j));
    end
  end

  // Owner's byte stream, selected by the registered owner index.
  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (owner_q == 3'(j)) begin
        own_data  = req_data[8*j +: 8];
        own_valid = req_valid[j];
        own_last  = req_last[j];
      end
    end
  end

  assign xfer          = (state_q == DATA) && own_valid && out_ready;
  // The burst limit check is compiled away entirely when MAX_BURST = 0.
  assign burst_full    = (MAX_BURST != 0) && ((cnt_q + 8'd1) == BURST_LIM);
  assign release_burst = xfer && (own_last || burst_full);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_found) state_d = HEADER_EN ? HEADER : DATA;
      HEADER:  if (out_ready) state_d = DATA;
      DATA:    if (release_burst) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. DATA is a combinational pass-through of the owner so the
  // requester's own valid/data stability carries straight to the transmitter.
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    req_ready = '0;
    unique case (state_q)
      HEADER: begin
        out_data  = hdr_q;
        out_valid = 1'b1;
      end
      DATA: begin
        out_data  = own_data;
        out_valid = own_valid;
        for (int j = 0; j < NUM_REQ; j++) begin
          req_ready[j] = (owner_q == 3'(j)) && out_ready;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant, owner, pointer, burst counter and header byte. A reset mid-burst
  // simply abandons the partial packet; nothing about it is remembered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      hdr_q   <= '0;
      grant_q <= '0;
    end else begin
      if (state_q == IDLE && win_found) begin
        owner_q <= win_idx;
        grant_q <= win_onehot;
        cnt_q   <= '0;
        hdr_q   <= {4'hA, 1'b0, win_idx};
      end
      if (xfer) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (release_burst) begin
        last_q  <= owner_q;
        grant_q <= '0;
      end
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_rs232_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_rs232_tx_arb
//   Directed bench for rs232_tx_arb (NUM_REQ = 4, HEADER_EN = 1, MAX_BURST = 4).
//   Requester sources are byte queues; expected transmitter bytes are pushed to
//   a scoreboard queue as each scenario is set up and popped whenever the DUT
//   completes an out_valid/out_ready transfer.
// -----------------------------------------------------------------------------
module tb_rs232_tx_arb;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;

  logic                 clock;
  logic                 resetn;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;

  rs232_tx_arb #(
    .NUM_REQ   (NUM_REQ),
    .HEADER_EN (1'b1),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  logic [8:0]         src_q [NUM_REQ][$];   // {last, data} per requester
  logic [7:0]         exp_q [$];            // scoreboard of transmitter bytes
  logic [NUM_REQ-1:0] hold;                 // force a requester's valid low
  logic [NUM_REQ-1:0] pop_flag;
  logic               rdy;
  logic               prev_stall;
  logic [7:0]         prev_data;

  logic [NUM_REQ-1:0] snap_grant;
  logic [NUM_REQ-1:0] snap_rr;
  logic               snap_busy;
  logic               snap_ov;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input int r, input logic [7:0] base, input logic [7:0] inc, input int n);
    for (int j = 0; j < n; j++) begin
      src_q[r].push_back({(j == n - 1), 8'(base + inc * 8'(j))});
    end
  endtask

  task automatic exp_hdr(input int r);
    exp_q.push_back({4'hA, 1'b0, 3'(r)});
  endtask

  task automatic exp_bytes(input logic [7:0] base, input logic [7:0] inc, input int from, input int n);
    for (int j = from; j < from + n; j++) begin
      exp_q.push_back(8'(base + inc * 8'(j)));
    end
  endtask

  function automatic bit srcs_pending();
    bit any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) any = 1'b1;
    end
    return any;
  endfunction

  // One clock cycle: drive inputs just after the edge, observe at the falling
  // edge, retire accepted source bytes at the next rising edge.
  task automatic step();
    logic [8:0]  head;
    logic [15:0] exp16;
    #1;
    out_ready = rdy;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        head              = src_q[i][0];
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = head[7:0];
        req_last[i]       = head[8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
    @(negedge clock);
    snap_grant = grant;
    snap_rr    = req_ready;
    snap_busy  = busy;
    snap_ov    = out_valid;
    if (prev_stall) begin
      check("stall_valid", 16'(out_valid), 16'd1);
      check("stall_data", 16'(out_data), 16'(prev_data));
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && out_ready) begin
      exp16 = (exp_q.size() > 0) ? {8'h00, exp_q.pop_front()} : 16'hDEAD;
      check("out_byte", {8'h00, out_data}, exp16);
    end
    for (int i = 0; i < NUM_REQ; i++) pop_flag[i] = req_valid[i] && req_ready[i];
    @(posedge clock);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pop_flag[i]) void'(src_q[i].pop_front());
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || srcs_pending()) && n < budget) begin
      step();
      n++;
    end
    check("drain_left", 16'(exp_q.size()), 16'd0);
    step();
    check("idle_busy", 16'(snap_busy), 16'd0);
    check("idle_grant", 16'(snap_grant), 16'd0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    #1;
    resetn = 1'b0;
    #1;
    check("rst_grant", 16'(grant), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_data", 16'(out_data), 16'd0);
    check("rst_ready", 16'(req_ready), 16'd0);
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete();
    hold       = '0;
    prev_stall = 1'b0;
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [3:0] t1_grant [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
  logic       t4_rdy   [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [3:0] t4_rr    [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0};
  logic       t4_ov    [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    resetn     = 1'b1;
    out_ready  = 1'b1;
    rdy        = 1'b1;
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;
    hold       = '0;
    prev_stall = 1'b0;
    prev_data  = '0;
    #2;
    do_reset();

    // Single requester 2: A2,11,22,33; grant held from the cycle after valid.
    add_pkt(2, 8'h11, 8'h11, 3);
    exp_hdr(2);
    exp_bytes(8'h11, 8'h11, 0, 3);
    for (int c = 0; c < 6; c++) begin
      step();
      check("t1_grant", 16'(snap_grant), 16'(t1_grant[c]));
    end
    drain(20);

    // Requesters 0 and 1 with back-to-back 2-byte packets: strict alternation.
    do_reset();
    add_pkt(0, 8'h01, 8'h01, 2);
    add_pkt(0, 8'h03, 8'h01, 2);
    add_pkt(1, 8'h81, 8'h01, 2);
    add_pkt(1, 8'h83, 8'h01, 2);
    exp_hdr(0); exp_bytes(8'h01, 8'h01, 0, 2);
    exp_hdr(1); exp_bytes(8'h81, 8'h01, 0, 2);
    exp_hdr(0); exp_bytes(8'h03, 8'h01, 0, 2);
    exp_hdr(1); exp_bytes(8'h83, 8'h01, 0, 2);
    step();
    check("t2_idle_grant", 16'(snap_grant), 16'd0);
    step();
    check("t2_first_grant", 16'(snap_grant), 16'b0001);
    drain(60);

    // 10-byte packet from requester 3 split by MAX_BURST = 4.
    add_pkt(3, 8'h30, 8'h01, 10);
    exp_hdr(3); exp_bytes(8'h30, 8'h01, 0, 4);
    exp_hdr(3); exp_bytes(8'h30, 8'h01, 4, 4);
    exp_hdr(3); exp_bytes(8'h30, 8'h01, 8, 2);
    drain(60);

    // out_ready stalls in header and data phases; req_ready mirrors out_ready.
    add_pkt(1, 8'h51, 8'h01, 3);
    exp_hdr(1);
    exp_bytes(8'h51, 8'h01, 0, 3);
    for (int c = 0; c < 10; c++) begin
      rdy = t4_rdy[c];
      step();
      check("t4_req_ready", 16'(snap_rr), 16'(t4_rr[c]));
      check("t4_out_valid", 16'(snap_ov), 16'(t4_ov[c]));
    end
    rdy = 1'b1;
    drain(20);

    // Owner 0 pauses mid-packet while requester 1 waits: lock is kept.
    add_pkt(0, 8'h01, 8'h01, 3);
    add_pkt(1, 8'h91, 8'h01, 1);
    exp_hdr(0); exp_bytes(8'h01, 8'h01, 0, 3);
    exp_hdr(1); exp_bytes(8'h91, 8'h01, 0, 1);
    for (int c = 0; c < 3; c++) step();
    hold[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("t5_grant", 16'(snap_grant), 16'b0001);
      check("t5_out_valid", 16'(snap_ov), 16'd0);
      check("t5_nonowner_ready", 16'(snap_rr[1]), 16'd0);
    end
    hold[0] = 1'b0;
    drain(40);

    // Reset in the middle of requester 2's data phase.
    add_pkt(2, 8'h21, 8'h01, 4);
    exp_hdr(2);
    exp_bytes(8'h21, 8'h01, 0, 1);
    for (int c = 0; c < 3; c++) step();
    check("t6_busy_before", 16'(busy), 16'd1);
    do_reset();
    add_pkt(2, 8'h25, 8'h01, 1);
    add_pkt(0, 8'h05, 8'h01, 1);
    exp_hdr(0); exp_bytes(8'h05, 8'h01, 0, 1);
    exp_hdr(2); exp_bytes(8'h25, 8'h01, 0, 1);
    step();
    step();
    check("t6_grant_after_rst", 16'(snap_grant), 16'b0001);
    drain(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rs232_tx_arb.md
Name: rs232_tx_arb

Overview:
- Shares the single rs232_send3 transmitter (valid/ready byte sink) between NUM_REQ byte-stream requesters, e.g. the loopback FIFO, a status reporter and a register-dump source.
- Round-robin, packet-locked arbitration: a granted requester keeps the transmitter until its last byte, or until MAX_BURST bytes have been sent.
- Optionally sends a channel-ID header byte before each granted burst, so the host can demultiplex the streams.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- HEADER_EN, 1, 1 = send a header byte before each burst; 0 = no header.
- MAX_BURST, 16, maximum data bytes per grant; 0 = unlimited; legal range 0..255.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
- req_valid  input  NUM_REQ  requester i has a byte.
- req_last  input  NUM_REQ  requester i's current byte ends its packet.
- req_ready  output  NUM_REQ  byte of requester i is accepted this cycle.
- out_data  output  8  byte to the transmitter.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  transmitter accepts out_data.
- grant  output  NUM_REQ  one-hot index of the current owner; all zero when idle.
- busy  output  1  1 in the HEADER and DATA states.

Behaviour:
- Reset (asynchronous):
  - state = IDLE; grant = 0; busy = 0; out_valid = 0; out_data = 0; req_ready = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
  - Burst counter = 0.
- Handshake: a byte transfers on a clock edge where valid && ready are both 1.
  - out_data and out_valid must stay stable while out_valid && !out_ready.
- IDLE:
  - Search req_valid starting at index last+1, wrapping modulo NUM_REQ; the first set bit is the winner k.
  - If a winner exists, on the next edge: grant = onehot(k), busy = 1, counter = 0.
  - Next state is HEADER if HEADER_EN = 1, otherwise DATA.
  - No winner: remain in IDLE.
  - req_ready = 0 and out_valid = 0 throughout IDLE.
- HEADER:
  - out_data = {4'hA, 1'b0, k[2:0]}, registered; out_valid = 1.
  - Go to DATA on out_ready; hold while out_ready = 0.
  - req_ready = 0.
- DATA (combinational pass-through of the owner k):
  - out_data = req_data[k]; out_valid = req_valid[k].
  - req_ready[k] = out_ready; all other req_ready bits = 0.
  - On each transfer the counter increments.
  - Release on a transfer with req_last[k] = 1, or with counter+1 == MAX_BURST when MAX_BURST != 0.
  - On release, on the same edge: state = IDLE, last = k, grant = 0, busy = 0.
- Arbitration latency:
  - A request seen in IDLE is granted on the next edge.
  - With HEADER_EN = 1, the first data byte can transfer no earlier than the second cycle after the grant.
  - At least one IDLE cycle separates consecutive grants, so back-to-back throughput is bounded by the transmitter, not by the arbiter.
- Boundary conditions:
  - The owner drops req_valid in mid-packet: the lock is kept; out_valid = 0; wait without limit (no timeout).
  - Burst forced out by MAX_BURST: the owner's next byte is sent in a later grant and gets a fresh header.
  - The requester being released asserts req_valid again in the same cycle: it competes in IDLE with the lowest round-robin priority.
  - A new request arrives while another requester is granted: it is only considered in the next IDLE cycle.
  - req_valid for a requester other than the owner: ignored; its req_ready = 0.
  - req_last outside DATA, or from a non-owner: ignored.
  - Reset asserted mid-burst: return immediately to the reset state; the partial packet is abandoned and the header is not resent.
- Width rules:
  - Counter is 8 bits; its comparison is disabled when MAX_BURST = 0.
  - The index k is 3 bits wide, zero-extended into the header byte.

Test Plan:
- Single requester 2, packet 0x11,0x22,0x33 (last on 0x33), out_ready = 1, HEADER_EN = 1 -> out stream 0xA2,0x11,0x22,0x33; grant = 4'b0100 from the cycle after req_valid until the 0x33 transfer; then IDLE.
- Requesters 0 and 1 each continuously sending 2-byte packets -> headers alternate 0xA0,0xA1,0xA0,...; no byte interleaving inside a packet; first grant after reset goes to 0.
- MAX_BURST = 4, requester 3 sends a 10-byte packet -> 0xA3 + 4 bytes, 0xA3 + 4 bytes, 0xA3 + 2 bytes; no other requester active.
- out_ready toggling 1,0,0,1 during the header and data phases -> out_data and out_valid held stable while stalled; no byte lost or duplicated; req_ready[k] mirrors out_ready.
- Owner deasserts req_valid for 5 cycles in mid-packet while requester 1 is valid -> grant unchanged; out_valid = 0 for those cycles; requester 1 is served only after the owner's last byte.
- Reset pulsed during the DATA state of requester 2 -> next cycle: grant = 0, out_valid = 0, busy = 0; the next arbitration starts at requester 0.
